// File: rtl/async_pkg.sv
// Frame format shared by the start/stop serial link: receiver and transmitter
// both take their line levels, bit order and default bit period from here.
package async_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE      = 3'd0;
    localparam state_t START     = 3'd1;
    localparam state_t DATA      = 3'd2;
    localparam state_t PARITY    = 3'd3;
    localparam state_t STOP      = 3'd4;
    localparam state_t WAIT_IDLE = 3'd5;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam bit   LSB_FIRST   = 1'b1;

    localparam int DEFAULT_CLKS_PER_BIT = 4;

endpackage

// File: rtl/async_rx_sync2.sv
// Two-flop synchronizer for the asynchronous RX pin; resets to the idle
// (high) level so a reset never looks like a start bit.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/async_rx.sv
// Start/stop serial receiver: oversamples RX, checks the start bit mid-period,
// shifts in the data bits, optional even parity and stop bit.
module async_rx
    import async_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int PARITY_EN    = 1
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              RX,
    output logic [DATA_W-1:0] Data,
    output logic              Valid,
    output logic              ParityErr,
    output logic              FrameErr,
    output logic              Busy,
    output state_t            state_dbg
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    // Valid is a one-cycle strobe with no back-pressure: the consumer must
    // take Data and qualify it with ParityErr/FrameErr on the cycle Valid is high.

    logic              rx_s;
    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  bit_pos;
    logic [DATA_W-1:0] shift;
    logic              perr;

    sync2 u_sync (
        .clk   (CLK),
        .rst_n (RSTn),
        .d     (RX),
        .q     (rx_s)
    );

    assign bit_pos   = LSB_FIRST ? idx : (IDX_LAST - idx);
    assign Busy      = (state != IDLE);
    assign state_dbg = state;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shift     <= '0;
            perr      <= 1'b0;
            Data      <= '0;
            Valid     <= 1'b0;
            ParityErr <= 1'b0;
            FrameErr  <= 1'b0;
        end else begin
            Valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_s == START_LEVEL) begin
                        cnt   <= CNT_HALF;
                        state <= START;
                    end
                end
                START: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (rx_s == START_LEVEL) begin
                        cnt   <= CNT_FULL;
                        idx   <= '0;
                        perr  <= 1'b0;
                        state <= DATA;
                    end else begin
                        // Line went back high before mid-start: treat as noise.
                        state <= IDLE;
                    end
                end
                DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        shift[bit_pos] <= rx_s;
                        cnt            <= CNT_FULL;
                        if (idx == IDX_LAST) begin
                            state <= (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        perr  <= rx_s ^ (^shift);
                        cnt   <= CNT_FULL;
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        Data      <= shift;
                        Valid     <= 1'b1;
                        ParityErr <= (PARITY_EN != 0) ? perr : 1'b0;
                        FrameErr  <= (rx_s != STOP_LEVEL);
                        state     <= (rx_s == IDLE_LEVEL) ? IDLE : WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    // A held-low line (break) must not be mistaken for a new start.
                    if (rx_s == IDLE_LEVEL) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_async_rx.sv
// Directed bench for async_rx: a table of single frames, then hand-written
// framing-error, glitch, back-to-back and reset-mid-frame sequences.
module tb_async_rx;
    import async_pkg::*;

    localparam int DATA_W = 8;
    localparam int CPB    = 4;
    localparam int PAR    = 1;
    localparam int HALF   = CPB / 2;
    localparam int LAT    = 2 + HALF + (DATA_W + PAR + 1) * CPB;  // E1 -> Valid edge
    localparam int GAP    = (DATA_W + PAR + 2) * CPB;             // one frame length

    logic              CLK  = 1'b0;
    logic              RSTn = 1'b0;
    logic              RX   = 1'b1;
    logic [DATA_W-1:0] Data;
    logic              Valid;
    logic              ParityErr;
    logic              FrameErr;
    logic              Busy;
    state_t            state_dbg;

    async_rx #(
        .DATA_W       (DATA_W),
        .CLKS_PER_BIT (CPB),
        .PARITY_EN    (PAR)
    ) dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .RX        (RX),
        .Data      (Data),
        .Valid     (Valid),
        .ParityErr (ParityErr),
        .FrameErr  (FrameErr),
        .Busy      (Busy),
        .state_dbg (state_dbg)
    );

    // clock / cycle counter
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // scoreboard: expected words in order, plus the cycle of every Valid seen
    logic [DATA_W-1:0] exp_q[$];
    int                valid_cyc[$];

    always @(negedge CLK) begin
        if (Valid === 1'b1) begin
            valid_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("valid_unexpected", 32'(Valid), 32'd0);
            end else begin
                check("sb_data", 32'(Data), 32'(exp_q.pop_front()));
            end
        end
    end

    // driver: called at a negedge, leaves the line at the stop level at a negedge
    task automatic send_frame(input logic [DATA_W-1:0] d, input logic par,
                              input logic stop, output int e1);
        RX = 1'b0;
        e1 = cyc + 1;
        repeat (CPB) @(negedge CLK);
        for (int i = 0; i < DATA_W; i++) begin
            RX = d[i];
            repeat (CPB) @(negedge CLK);
        end
        if (PAR != 0) begin
            RX = par;
            repeat (CPB) @(negedge CLK);
        end
        RX = stop;
        repeat (CPB) @(negedge CLK);
    endtask

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              par;
        logic              exp_perr;
    } vec_t;

    vec_t              vecs[6];
    int                e1;
    int                e2;
    int                busy_cnt;
    logic [DATA_W-1:0] pat;

    initial begin
        vecs[0] = '{data: 8'h8A, par: 1'b1, exp_perr: 1'b0};
        vecs[1] = '{data: 8'hAA, par: 1'b1, exp_perr: 1'b1};
        vecs[2] = '{data: 8'h3C, par: 1'b0, exp_perr: 1'b0};
        vecs[3] = '{data: 8'h01, par: 1'b0, exp_perr: 1'b1};
        vecs[4] = '{data: 8'hFF, par: 1'b0, exp_perr: 1'b0};
        vecs[5] = '{data: 8'h7E, par: 1'b0, exp_perr: 1'b0};

        // reset state
        RX   = 1'b1;
        RSTn = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_data",  32'(Data),      32'd0);
        check("rst_valid", 32'(Valid),     32'd0);
        check("rst_perr",  32'(ParityErr), 32'd0);
        check("rst_ferr",  32'(FrameErr),  32'd0);
        check("rst_busy",  32'(Busy),      32'd0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        RSTn = 1'b1;
        repeat (4) @(negedge CLK);

        // single frames from the table
        for (int v = 0; v < 6; v++) begin
            valid_cyc.delete();
            exp_q.push_back(vecs[v].data);
            send_frame(vecs[v].data, vecs[v].par, 1'b1, e1);
            repeat (6) @(negedge CLK);
            check($sformatf("v%0d_count", v), 32'(valid_cyc.size()), 32'd1);
            if (valid_cyc.size() > 0)
                check($sformatf("v%0d_time", v), 32'(valid_cyc[0] - e1), 32'(LAT));
            check($sformatf("v%0d_data", v), 32'(Data),      32'(vecs[v].data));
            check($sformatf("v%0d_perr", v), 32'(ParityErr), 32'(vecs[v].exp_perr));
            check($sformatf("v%0d_ferr", v), 32'(FrameErr),  32'd0);
            check($sformatf("v%0d_busy", v), 32'(Busy),      32'd0);
        end

        // framing error: stop bit low, line held low three more bit times
        valid_cyc.delete();
        exp_q.push_back(8'hCA);
        send_frame(8'hCA, 1'b0, 1'b0, e1);
        repeat (3 * CPB) @(negedge CLK);
        check("fe_count", 32'(valid_cyc.size()), 32'd1);
        if (valid_cyc.size() > 0)
            check("fe_time", 32'(valid_cyc[0] - e1), 32'(LAT));
        check("fe_ferr",  32'(FrameErr),  32'd1);
        check("fe_perr",  32'(ParityErr), 32'd0);
        check("fe_state", 32'(state_dbg), 32'(WAIT_IDLE));
        check("fe_busy",  32'(Busy),      32'd1);
        RX = 1'b1;
        repeat (60) @(negedge CLK);
        check("fe_count_after", 32'(valid_cyc.size()), 32'd1);
        check("fe_state_idle",  32'(state_dbg),         32'(IDLE));
        check("fe_ferr_held",   32'(FrameErr),          32'd1);
        check("fe_data_held",   32'(Data),              32'hCA);

        // one-clock low glitch
        valid_cyc.delete();
        busy_cnt = 0;
        RX = 1'b0;
        @(negedge CLK);
        RX = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (Busy === 1'b1) busy_cnt++;
        end
        check("gl_count",      32'(valid_cyc.size()),   32'd0);
        check("gl_busy_seen",  32'(busy_cnt > 0),       32'd1);
        check("gl_busy_short", 32'(busy_cnt <= HALF + 1), 32'd1);
        check("gl_ferr",       32'(FrameErr),           32'd1);
        check("gl_perr",       32'(ParityErr),          32'd0);
        check("gl_data",       32'(Data),               32'hCA);

        // back-to-back frames with no idle gap
        valid_cyc.delete();
        exp_q.push_back(8'hEA);
        exp_q.push_back(8'h0F);
        send_frame(8'hEA, 1'b1, 1'b1, e1);
        send_frame(8'h0F, 1'b0, 1'b1, e2);
        repeat (6) @(negedge CLK);
        check("bb_count", 32'(valid_cyc.size()), 32'd2);
        if (valid_cyc.size() == 2) begin
            check("bb_time0", 32'(valid_cyc[0] - e1),           32'(LAT));
            check("bb_gap",   32'(valid_cyc[1] - valid_cyc[0]), 32'(GAP));
        end
        check("bb_data", 32'(Data),      32'h0F);
        check("bb_ferr", 32'(FrameErr),  32'd0);
        check("bb_perr", 32'(ParityErr), 32'd0);

        // reset after four data bits of 0x55
        valid_cyc.delete();
        pat = 8'h55;
        RX  = 1'b0;
        repeat (CPB) @(negedge CLK);
        for (int i = 0; i < 4; i++) begin
            RX = pat[i];
            repeat (CPB) @(negedge CLK);
        end
        check("mr_busy_before", 32'(Busy), 32'd1);
        RSTn = 1'b0;
        #1;
        check("mr_data",  32'(Data),      32'd0);
        check("mr_valid", 32'(Valid),     32'd0);
        check("mr_perr",  32'(ParityErr), 32'd0);
        check("mr_ferr",  32'(FrameErr),  32'd0);
        check("mr_busy",  32'(Busy),      32'd0);
        check("mr_state", 32'(state_dbg), 32'(IDLE));
        RX = 1'b1;
        repeat (3) @(negedge CLK);
        RSTn = 1'b1;
        repeat (6) @(negedge CLK);
        check("mr_no_valid", 32'(valid_cyc.size()), 32'd0);

        valid_cyc.delete();
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b0, 1'b1, e1);
        repeat (6) @(negedge CLK);
        check("mr_next_count", 32'(valid_cyc.size()), 32'd1);
        if (valid_cyc.size() > 0)
            check("mr_next_time", 32'(valid_cyc[0] - e1), 32'(LAT));
        check("mr_next_data", 32'(Data),      32'h3C);
        check("mr_next_perr", 32'(ParityErr), 32'd0);
        check("mr_next_ferr", 32'(FrameErr),  32'd0);

        check("sb_drained", 32'(exp_q.size()), 32'd0);

        // report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/async_rx.md
# async_rx

Asynchronous serial receiver: the receiving end of the team's start/stop serial link. It oversamples a single RX line with the system clock, validates the start bit, and shifts in DATA_W data bits LSB first, plus an optional even-parity bit and a stop bit. It presents the recovered word with a one-cycle valid strobe and per-frame error flags. It sits between the link pin and the display/consumer logic, mirroring the transmitter's frame format.

## Interface
- `DATA_W`, 8: data bits per frame.
- `CLKS_PER_BIT`, 4: system clocks per bit period; must be even and ≥4.
- `PARITY_EN`, 1: 1 = even-parity bit after the data; 0 = no parity bit.
- `CLK` input, 1: system clock, rising edge.
- `RSTn` input, 1: asynchronous, active-low reset.
- `RX` input, 1: serial line, asynchronous to CLK; idles high.
- `Data` output, DATA_W: last received word.
- `Valid` output, 1: one-cycle strobe when a frame completes.
- `ParityErr` output, 1: parity mismatch in the last frame; held until the next frame completes.
- `FrameErr` output, 1: stop bit sampled low in the last frame; held until the next frame completes.
- `Busy` output, 1: high in every state other than IDLE.

## Operation
- `RX` passes through a 2-flop synchronizer to produce `Rx_s`. The FSM uses only `Rx_s`.
- Constant: `HALF = CLKS_PER_BIT/2`.
- The bit counter `cnt` and the bit index `idx` are sized as `$clog2` of their maximum values.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE: when `Rx_s` = 0, load `cnt = HALF-1` and go to START.
- START: decrement `cnt`. At `cnt` = 0, sample `Rx_s`:
  - 0: load `cnt = CLKS_PER_BIT-1`, `idx = 0`, go to DATA.
  - 1: false start; return to IDLE with no strobe and no flag change.
- DATA: at each `cnt` = 0, shift `Rx_s` into bit `idx` (LSB first) and reload `cnt`. After bit DATA_W-1, go to PARITY if `PARITY_EN`, otherwise to STOP.
- PARITY: at `cnt` = 0, compute `perr = Rx_s ^ (^shift)`. Even parity means the XOR of data and parity equals 0. Go to STOP.
- STOP: at `cnt` = 0, on the next edge:
  - `Data <= shift`, `Valid <= 1`, `ParityErr <= perr` (forced 0 when `PARITY_EN` = 0), `FrameErr <= ~Rx_s`.
  - If `Rx_s` = 1, go to IDLE; otherwise go to WAIT_IDLE.
- WAIT_IDLE: stay until `Rx_s` = 1, then go to IDLE. This prevents a break or low line from re-triggering.
- `Valid` fires on every completed frame, including errored ones. The consumer qualifies it with the two flags.
- `Data` changes only on the cycle `Valid` is high.

## Timing
- Reset values: `Data` = 0, `Valid` = 0, `ParityErr` = 0, `FrameErr` = 0, `Busy` = 0. FSM in IDLE, synchronizer flops = 1.
- Reset asserted mid-frame: all state clears immediately. The partial frame is discarded with no `Valid`.
- Reset deassertion with `RX` low: the receiver starts a frame once `Rx_s` = 0 is seen. The false-start check then decides.
- Let E1 be the first rising edge that samples `RX` = 0.
  - `Rx_s` = 0 after E2.
  - FSM enters START at E3.
  - The start bit is sampled at E3 + HALF.
  - Bit k is sampled CLKS_PER_BIT·(k+1) later.
- `Valid` is high during the cycle after edge E3 + HALF + (DATA_W + PARITY_EN + 1)·CLKS_PER_BIT.
  - With defaults this is edge E1 + 44, so `Valid` is visible after E1 + 44 for exactly one cycle.
- A low glitch shorter than HALF cycles is rejected as a false start.
- Back-to-back frames: a start edge arriving on the cycle the FSM returns to IDLE is accepted. There is no dead cycle beyond the IDLE check.
- `Busy` rises with entry to START (E3) and falls on entry to IDLE.

## Structure
- Shared package `async_pkg`:
  - State enum: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - Frame-format constants: idle level = 1, start level = 0, stop level = 1, LSB-first.
  - Default `CLKS_PER_BIT`.
  - The transmitter uses the same constants.
- One sub-module `sync2`: a parameterless 2-flop synchronizer with async active-low reset to 1.
- Everything else is inline in `async_rx`.

## Test plan
- Good frame: `PARITY_EN` = 1, send 0x8A with parity 1 and stop 1. Required: `Valid` pulses once at E1+44, `Data` = 0x8A, `ParityErr` = 0, `FrameErr` = 0.
- Parity error: send 0xAA with parity 1 (correct is 0). Required: `Valid` pulses, `Data` = 0xAA, `ParityErr` = 1. `ParityErr` is held until the next good frame, which clears it.
- Framing error: send 0xCA with the stop bit low and the line held low for 3 more bit times. Required: `Valid` pulses, `FrameErr` = 1, FSM stays in WAIT_IDLE, and no second frame is decoded until `RX` returns high.
- Glitch: drive `RX` low for 1 clock, then high. Required: no `Valid`, all flags unchanged, `Busy` high for at most HALF+1 cycles.
- Back-to-back: transmit 0xEA immediately followed by 0x0F. Required: two `Valid` pulses exactly (DATA_W+3)·CLKS_PER_BIT = 44 cycles apart, carrying 0xEA and then 0x0F.
- Reset mid-frame: assert `RSTn` low after 4 data bits of 0x55. Required: all outputs are 0 immediately. A following clean 0x3C frame is received correctly.
